// File: rtl/io_uart_mmio_if.sv
// io_uart_mmio_if: load/store request bus from the memory stage to the I/O region.
// Read data in dout is registered and valid one cycle after the request.
interface io_uart_mmio_if;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] din;
   logic [31:0] dout;

   modport master (output en, output we, output addr, output din, input dout);
   modport slave  (input en, input we, input addr, input din, output dout);
endinterface

// File: rtl/io_uart_mmio.sv
// io_uart_mmio: MMIO responder with UART TX byte FIFO, cycle counter and optional UART RX.
// Define IO_UART_RX_EN to build the receiver, its synchronizer and the 0x04 rx data register.
module io_uart_mmio #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned TX_DEPTH     = 8
) (
   input  logic          clk,
   input  logic          rst,
   io_uart_mmio_if.slave bus,
   output logic          serial_out,
   input  logic          serial_in
);
   localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
   localparam int unsigned   AW      = $clog2(TX_DEPTH);
   localparam logic [CW-1:0] BitLast = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   Full    = (AW + 1)'(TX_DEPTH);

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

   logic        sel, rd, wr, push_req, push, tx_pop, full, empty, clr;
   logic [7:0]  off;
   logic [31:0] rd_data, dout_q, cycle_q;
   logic        rx_valid, rx_overrun;
   logic [7:0]  rx_byte;

   assign sel      = bus.addr[31:28] == 4'h8;
   assign off      = bus.addr[7:0];
   assign rd       = bus.en && (bus.we == 4'b0);
   assign wr       = bus.en && (bus.we != 4'b0) && sel;
   assign push_req = wr && (off == 8'h08);
   assign clr      = wr && (off == 8'h18);

   // TX FIFO; a push on a full FIFO is still accepted when the same cycle pops.
   logic [7:0]    fifo_mem [TX_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          tx_overflow_q;

   assign full  = count_q == Full;
   assign empty = count_q == '0;
   assign push  = push_req && (!full || tx_pop);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= bus.din[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         tx_overflow_q <= 1'b0;
      end else begin
         if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
         if (tx_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, tx_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push_req && !push) tx_overflow_q <= 1'b1;
      end
   end

   // TX FSM; the line is registered from the current state, so it trails the state by a cycle.
   tx_state_e     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_line_q, tx_line_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         TxIdle: begin
            if (!empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = fifo_mem[rd_ptr_q];
               tx_cnt_d   = '0;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TxData;
            end else tx_cnt_d = tx_cnt_q + 1'b1;
         end
         TxData: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_shift_d = tx_shift_q >> 1;
               if (tx_bit_q == 3'd7) tx_state_d = TxStop;
               else tx_bit_d = tx_bit_q + 1'b1;
            end else tx_cnt_d = tx_cnt_q + 1'b1;
         end
         TxStop: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_state_d = TxIdle;
            end else tx_cnt_d = tx_cnt_q + 1'b1;
         end
         default: tx_state_d = TxIdle;
      endcase
      tx_line_d = (tx_state_q == TxStart) ? 1'b0 :
                  (tx_state_q == TxData)  ? tx_shift_q[0] : 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_line_q  <= tx_line_d;
      end
   end

   assign serial_out = tx_line_q;

`ifdef IO_UART_RX_EN
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d, rx_byte_q;
   logic          rx_s1_q, rx_s2_q, rx_s3_q, rx_done, rx_read, rx_valid_q, rx_overrun_q;

   assign rx_read = rd && sel && (off == 8'h04);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_s3_q && !rx_s2_q) begin
               rx_cnt_d   = '0;
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (rx_cnt_q == HalfLast) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RxIdle : RxData;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
         end
         RxData: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RxStop;
               else rx_bit_d = rx_bit_q + 1'b1;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
         end
         RxStop: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = '0;
               rx_done    = rx_s2_q;
               rx_state_d = RxIdle;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
         rx_state_q   <= RxIdle;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_byte_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         {rx_s1_q, rx_s2_q, rx_s3_q} <= {serial_in, rx_s1_q, rx_s2_q};
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         // A completion racing a read keeps valid set and is not an overrun.
         if (rx_done) begin
            rx_byte_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
         end else if (rx_read) rx_valid_q <= 1'b0;
         if (rx_read) rx_overrun_q <= 1'b0;
         else if (rx_done && rx_valid_q) rx_overrun_q <= 1'b1;
      end
   end

   assign rx_valid   = rx_valid_q;
   assign rx_overrun = rx_overrun_q;
   assign rx_byte    = rx_byte_q;
`else
   assign rx_valid   = 1'b0;
   assign rx_overrun = 1'b0;
   assign rx_byte    = 8'h00;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cycle_q <= '0;
      else if (clr) cycle_q <= '0;
      else          cycle_q <= cycle_q + 1'b1;
   end

   always_comb begin
      rd_data = '0;
      if (sel) begin
         case (off)
            8'h00:   rd_data = {28'b0, rx_overrun, tx_overflow_q, rx_valid, !full};
            8'h04:   rd_data = {24'b0, rx_byte};
            8'h10:   rd_data = cycle_q;
            default: rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     dout_q <= '0;
      else if (rd) dout_q <= rd_data;
   end

   assign bus.dout = dout_q;

   logic unused_bits;
   assign unused_bits = ^{bus.addr[27:8], bus.din[31:8], serial_in};
endmodule

// File: doc/io_uart_mmio.md
# io_uart_mmio

Memory-mapped I/O responder that services the load/store requests the memory stage issues to the I/O region. It provides a UART transmitter with a byte FIFO, an optional UART receiver with a one-byte holding register, and a free-running cycle counter. Read data returns one cycle after the request, the same latency as the synchronous data memory, so the write-back mux treats both alike.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit; 434 gives 115200 baud at 50 MHz; minimum 4.
- `TX_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; every register is on its rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `en` in 1: access strobe for this cycle's request.
- `we` in 4: byte write enables; any nonzero bit with `en` makes the access a write.
- `addr` in 32: byte address; selected when `addr[31:28]==4'h8`; register offset is `addr[7:0]`.
- `din` in 32: store data.
- `dout` out 32: registered load data.
- `serial_out` out 1: UART TX line; idles high.
- `serial_in` in 1: UART RX line; asynchronous to `clk`.

## Operation
- Register map (offset):
  - 0x00 R status: {28'b0, rx_overrun, tx_overflow, rx_valid, tx_ready}.
  - 0x04 R rx data: {24'b0, rx_byte}; the read clears rx_valid and rx_overrun.
  - 0x08 W tx data: pushes `din[7:0]`.
  - 0x10 R cycle counter.
  - 0x18 W clears the cycle counter; write data is ignored.
- Unmapped offsets and non-selected addresses: reads return 0, writes have no effect.
- tx_ready = FIFO not full. A write to 0x08 while full drops the byte and sets sticky tx_overflow; only reset clears tx_overflow.
- TX FSM IDLE→START→DATA→STOP→IDLE:
  - IDLE pops the FIFO when it is non-empty.
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA sends 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP drives 1 for CLKS_PER_BIT cycles.
  - STOP returns to IDLE; a pending byte is popped on the following edge, giving one idle cycle between frames.
- RX FSM IDLE→START→DATA→STOP:
  - `serial_in` passes through a 2-flop synchronizer.
  - A synchronized 1→0 edge in IDLE enters START.
  - START samples at CLKS_PER_BIT/2 (integer divide). If the sample is high it is a false start and the FSM returns to IDLE.
  - Eight data samples follow, each CLKS_PER_BIT apart, then one stop sample.
  - Stop sample high: load rx_byte and set rx_valid. If rx_valid was already set, the byte is overwritten and rx_overrun is set.
  - Stop sample low: frame discarded, no flag change.
- Cycle counter: 32-bit, increments every cycle, wraps from 0xFFFFFFFF to 0.

## Timing
- Read with `en` && `we==0` at edge N: `dout` holds the value at edge N+1 and keeps it until the next read. Writes do not alter `dout`.
- Status and counter reads return the value before edge N's updates.
- Write to 0x08 at edge N: tx_ready reflects the new occupancy at N+1. If the FIFO was empty and TX is IDLE, the pop happens at N+1 and `serial_out` falls at N+2.
- Frame length is 10×CLKS_PER_BIT cycles.
- Simultaneous events:
  - Push and pop in the same cycle on a full FIFO: the push is accepted.
  - RX completion in the same cycle as a 0x04 read: the read returns the old byte, the new byte loads, and rx_valid stays 1 with no overrun.
  - 0x18 write and increment in the same cycle: counter = 0 at the next edge.
- Reset values (async, immediate on `rst`):
  - `dout`=0, `serial_out`=1.
  - FIFO empty, both FSMs IDLE.
  - rx_byte=0; all flags 0 except tx_ready=1; counter=0.
- Reset mid-frame abandons the frame; `serial_out` goes high immediately.

## Configuration
- `IO_UART_RX_EN` defined: receiver, synchronizer, rx_valid, rx_overrun, and the 0x04 register are built.
- Not defined: no RX logic; `serial_in` is ignored; status bits 1 and 3 read 0; 0x04 reads 0. TX, counter and read timing are unchanged.

## Test plan
- Reset, then read 0x00 and 0x10 on consecutive cycles → `dout`=0x1, then a small count; `serial_out`=1 throughout.
- CLKS_PER_BIT=4, write 0x08 `din`=0x000000A5 → `serial_out` falls 2 cycles later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high; frame = 40 cycles.
- TX_DEPTH=8, write 10 bytes back to back while TX IDLE → first byte popped; status reads 0x1 until the FIFO is full, then 0x0; the 10th byte is dropped and status bit 2 is set.
- (`IO_UART_RX_EN`) drive frame 0x3C on `serial_in` → status=0x3, read 0x04 → 0x3C, status=0x1. Send two frames without reading → status bit 3 set, 0x04 returns the second byte.
- (`IO_UART_RX_EN`) low glitch of CLKS_PER_BIT/2−1 cycles → no byte received, rx_valid stays 0.
- Write 0x18 at cycle N, read 0x10 at N+3 → `dout`=2; assert `rst` mid-frame → `serial_out`=1 in the same cycle.
